// File: rtl/uart_rx_oversample.sv
// UART receiver sampling a 2-flop-synchronised rx line on an external oversample tick.
// Recovers LSB-first frames with optional parity and flags stop-bit / parity errors.
module uart_rx_oversample #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_tick,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data_out,
   output logic                 o_rx_valid,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_busy
);

   // state   | meaning
   // S_IDLE  | line idle, waiting for a low sample
   // S_START | counting to the middle of the start bit
   // S_DATA  | sampling data bits at mid-bit
   // S_PARITY| sampling the parity bit
   // S_STOP  | sampling the stop bit, publishes the frame
   // S_BREAK | stop bit was low, wait for the line to return high

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic [TW-1:0]        r_tick_cnt;
   logic [TW-1:0]        w_tick_cnt_nxt;
   logic [BW-1:0]        r_bit_cnt;
   logic [BW-1:0]        w_bit_cnt_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 r_perr;
   logic                 w_perr_nxt;
   logic                 w_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_tick_cnt_nxt = r_tick_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_perr_nxt     = r_perr;
      w_done         = 1'b0;
      if (i_tick) begin
         w_tick_cnt_nxt = r_tick_cnt + TW'(1);
         case (r_state)
            S_IDLE: begin
               w_tick_cnt_nxt = '0;
               if (!r_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
               if (r_tick_cnt == TC_HALF) begin
                  w_tick_cnt_nxt = '0;
                  w_bit_cnt_nxt  = '0;
                  w_state_nxt    = r_rx_s ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (r_tick_cnt == TC_FULL) begin
                  w_tick_cnt_nxt = '0;
                  w_shift_nxt    = {r_rx_s, r_shift[DATA_BITS-1:1]};
                  w_bit_cnt_nxt  = r_bit_cnt + BW'(1);
                  if (r_bit_cnt == BC_LAST)
                     w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (r_tick_cnt == TC_FULL) begin
                  w_tick_cnt_nxt = '0;
                  w_perr_nxt     = (^r_shift) ^ r_rx_s ^ (PARITY_ODD != 0);
                  w_state_nxt    = S_STOP;
               end
            end
            S_STOP: begin
               if (r_tick_cnt == TC_FULL) begin
                  w_tick_cnt_nxt = '0;
                  w_done         = 1'b1;
                  // a low stop bit means the line may be held in break
                  w_state_nxt    = r_rx_s ? S_IDLE : S_BREAK;
               end
            end
            S_BREAK: begin
               w_tick_cnt_nxt = '0;
               if (r_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
               w_tick_cnt_nxt = '0;
               w_state_nxt    = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_tick_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_perr       <= 1'b0;
         o_data_out   <= '0;
         o_rx_valid   <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_perr     <= w_perr_nxt;
         o_rx_valid <= w_done;
         if (w_done) begin
            o_data_out   <= r_shift;
            o_frame_err  <= ~r_rx_s;
            o_parity_err <= (PARITY_EN != 0) ? r_perr : 1'b0;
         end
      end
   end

   assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: tick every 4 clk, 16x oversample,
// expected frames queued at send time and compared when rx_valid fires.
module tb_uart_rx_oversample;

   localparam int BIT_CLK = 64;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       rx;
   logic       rx_p;
   logic [7:0] data_out,  data_out_p;
   logic       rx_valid,  rx_valid_p;
   logic       frame_err, frame_err_p;
   logic       par_err,   par_err_p;
   logic       busy,      busy_p;

   int     checks = 0;
   int     failures = 0;
   int     valid_cnt = 0;
   int     valid_cnt_p = 0;
   longint cyc = 0;
   longint last_valid_cyc = 0;
   longint prev_valid_cyc = 0;
   exp_t   q[$];
   exp_t   qp[$];

   uart_rx_oversample u_dut (
      .clk(clk), .rst(rst), .i_tick(tick), .i_rx(rx),
      .o_data_out(data_out), .o_rx_valid(rx_valid), .o_frame_err(frame_err),
      .o_parity_err(par_err), .o_busy(busy)
   );

   uart_rx_oversample #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
      .clk(clk), .rst(rst), .i_tick(tick), .i_rx(rx_p),
      .o_data_out(data_out_p), .o_rx_valid(rx_valid_p), .o_frame_err(frame_err_p),
      .o_parity_err(par_err_p), .o_busy(busy_p)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      int tph;
      tph  = 0;
      tick = 1'b0;
      forever begin
         @(negedge clk);
         tph  = (tph + 1) % 4;
         tick = (tph == 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (q.size() == 0) chk("pending_expect", 32'(q.size()), 32'd1);
            else begin
               e = q.pop_front();
               chk("data_out", 32'(data_out), 32'(e.d));
               chk("frame_err", 32'(frame_err), 32'(e.fe));
               chk("parity_err", 32'(par_err), 32'(e.pe));
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_valid_p) begin
            valid_cnt_p++;
            if (qp.size() == 0) chk("pending_expect_p", 32'(qp.size()), 32'd1);
            else begin
               e = qp.pop_front();
               chk("data_out_p", 32'(data_out_p), 32'(e.d));
               chk("frame_err_p", 32'(frame_err_p), 32'(e.fe));
               chk("parity_err_p", 32'(par_err_p), 32'(e.pe));
            end
         end
      end
   end

   task automatic send_bit(input bit sel, input logic v);
      if (sel) rx_p = v;
      else     rx   = v;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                             input logic par, input logic stop);
      send_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
      if (has_par) send_bit(sel, par);
      send_bit(sel, stop);
   endtask

   initial begin
      int         v0;
      logic [7:0] c3;
      rst  = 1'b1;
      rx   = 1'b1;
      rx_p = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_valid", 32'(rx_valid), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_perr", 32'(par_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // clean 8N1 frame
      v0 = valid_cnt;
      q.push_back('{8'hA5, 1'b0, 1'b0});
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      chk("a5_pulses", 32'(valid_cnt - v0), 32'd1);
      chk("a5_busy_low", 32'(busy), 32'h0);

      // start-bit glitch
      v0 = valid_cnt;
      rx = 1'b0;
      repeat (20) @(negedge clk);
      chk("glitch_busy_high", 32'(busy), 32'h1);
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
      chk("glitch_busy_low", 32'(busy), 32'h0);
      chk("glitch_pulses", 32'(valid_cnt - v0), 32'd0);
      chk("glitch_data", 32'(data_out), 32'hA5);

      // low stop bit followed by a long break
      v0 = valid_cnt;
      q.push_back('{8'h5A, 1'b1, 1'b0});
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
      repeat (20 * BIT_CLK) @(negedge clk);
      chk("break_pulses", 32'(valid_cnt - v0), 32'd1);
      chk("break_busy", 32'(busy), 32'h1);
      chk("break_ferr_hold", 32'(frame_err), 32'h1);
      rx = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      chk("break_exit_busy", 32'(busy), 32'h0);
      q.push_back('{8'h11, 1'b0, 1'b0});
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      chk("after_break_data", 32'(data_out), 32'h11);
      chk("after_break_ferr", 32'(frame_err), 32'h0);

      // even parity instance
      v0 = valid_cnt_p;
      qp.push_back('{8'h37, 1'b0, 1'b0});
      send_frame(1'b1, 8'h37, 1'b1, 1'b1, 1'b1);
      chk("par_ok_flag", 32'(par_err_p), 32'h0);
      qp.push_back('{8'h37, 1'b0, 1'b1});
      send_frame(1'b1, 8'h37, 1'b1, 1'b0, 1'b1);
      chk("par_bad_flag", 32'(par_err_p), 32'h1);
      chk("par_bad_data", 32'(data_out_p), 32'h37);
      chk("par_pulses", 32'(valid_cnt_p - v0), 32'd2);

      // back-to-back frames, no idle gap
      v0 = valid_cnt;
      q.push_back('{8'h00, 1'b0, 1'b0});
      q.push_back('{8'hFF, 1'b0, 1'b0});
      send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      chk("b2b_pulses", 32'(valid_cnt - v0), 32'd2);
      chk("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(10 * BIT_CLK));
      chk("b2b_data", 32'(data_out), 32'hFF);

      // reset in the middle of a frame
      c3 = 8'hC3;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, c3[i]);
      rst = 1'b1;
      #1;
      chk("midrst_data", 32'(data_out), 32'h0);
      chk("midrst_valid", 32'(rx_valid), 32'h0);
      chk("midrst_ferr", 32'(frame_err), 32'h0);
      chk("midrst_perr", 32'(par_err), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      v0 = valid_cnt;
      repeat (2 * BIT_CLK) @(negedge clk);
      q.push_back('{8'h3C, 1'b0, 1'b0});
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      chk("post_rst_pulses", 32'(valid_cnt - v0), 32'd1);
      chk("post_rst_data", 32'(data_out), 32'h3C);

      repeat (BIT_CLK) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      chk("queue_drained_p", 32'(qp.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- UART serial receiver; sits directly downstream of the 16x baud tick generator.
- Consumes the generator's single-cycle tick as a sampling enable, recovers 8N1 frames (optional parity) from the asynchronous rx line, and presents parallel bytes with a one-cycle valid strobe.
- Stop-bit and parity errors are flagged to the host logic.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), sent LSB first.
- OVERSAMPLE, 16, ticks per bit period; even, >=4.
- PARITY_EN, 0, 1 = parity bit expected between data and stop.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  oversample enable, one clk wide, OVERSAMPLE per bit period (from baud generator done).
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  last received word.
- rx_valid  output  1  one-clk pulse: data_out / error flags updated.
- frame_err  output  1  stop bit sampled low on last frame.
- parity_err  output  1  parity mismatch on last frame (0 when PARITY_EN=0).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous, active-high, clock clk. Reset values:
  - data_out=0, rx_valid=0, frame_err=0, parity_err=0, busy=0.
  - Synchronizer flops = 1, state=IDLE, all counters 0.
- rx passes through a 2-flop synchronizer (rx_s); 2 clk latency. All decisions use rx_s only.
- State, tick_cnt (clog2(OVERSAMPLE) bits) and bit_cnt advance only on clk edges where tick=1; tick=0 holds everything except the rx_valid clear.
- States:
  - IDLE: on tick with rx_s=0 -> START, tick_cnt=0.
  - START: tick_cnt increments per tick.
    - On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit), rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0.
    - If rx_s=1 at that point, the start is a glitch -> IDLE; no rx_valid, no flag change.
  - DATA: on the tick where tick_cnt==OVERSAMPLE-1, shift rx_s into the MSB of the shift register (shift right, LSB first), tick_cnt=0, bit_cnt++.
    - After the DATA_BITS-th sample -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample after OVERSAMPLE ticks.
    - perr = (XOR of data bits XOR sampled bit) != PARITY_ODD.
    - -> STOP, tick_cnt=0.
  - STOP: sample after OVERSAMPLE ticks. Next clk edge:
    - data_out <= shift register; frame_err <= ~rx_s; parity_err <= perr (0 if PARITY_EN=0); rx_valid <= 1 for exactly one clk.
    - rx_s=1 -> IDLE.
    - rx_s=0 -> BREAK.
  - BREAK: stays until a tick with rx_s=1, then -> IDLE. A held-low line (break) yields exactly one rx_valid, not repeated frames.
- Data and flags are delivered even on error. Flags hold until the next rx_valid.
- Sampling point is the middle of every bit: the START alignment is OVERSAMPLE/2 ticks, later bits are full periods.
- Back-to-back frames: a start edge on the first IDLE tick after STOP is accepted. There is no idle-gap requirement.
- Reset mid-frame: partial frame discarded; no rx_valid.
- No host handshake. The consumer must capture data_out on rx_valid; an unread word is overwritten by the next frame.

Test Plan:
- Bench timing for all cases: tick every 4 clk, OVERSAMPLE=16, defaults unless stated.
- 8N1 frame 0xA5, stop=1 -> single rx_valid pulse, data_out=0xA5, frame_err=0, parity_err=0, busy low after stop.
- rx low for 5 ticks then high (glitch) -> no rx_valid, busy rises then returns to 0, data_out unchanged.
- Frame 0x5A with stop bit 0, then rx held low 20 bit times -> exactly one rx_valid, data_out=0x5A, frame_err=1. Then rx high, frame 0x11 -> data_out=0x11, frame_err=0.
- PARITY_EN=1 even: frame 0x37 with parity bit 1 -> parity_err=0. Same data with parity bit 0 -> parity_err=1, data_out=0x37.
- Back-to-back frames 0x00 then 0xFF, zero idle gap -> two rx_valid pulses 10 bit times apart, data 0x00 then 0xFF.
- rst asserted after 4 data bits of 0xC3 -> all outputs 0 immediately. After release, frame 0x3C -> data_out=0x3C, no spurious rx_valid.
